alu_issue_stage: RTL

//  ID/EX pipeline stage that drives the ALU input interface (aluop1, aluop2, alu_ctrl).

---
 rtl/alu_issue_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and controls, then
// applies MEM/WB forwarding and raises a one-cycle bubble on load-use hazards.
module alu_issue_stage #(
    parameter int LEN    = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [LEN-1:0]    id_rs1_data,
    input  logic [LEN-1:0]    id_rs2_data,
    input  logic [LEN-1:0]    id_imm,
    input  logic [LEN-1:0]    id_pc,
    input  logic [2:0]        id_alu_ctrl,
    input  logic              id_srca_pc,
    input  logic              id_srcb_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [LEN-1:0]    mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [LEN-1:0]    wb_result,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [LEN-1:0]    aluop1,
    output logic [LEN-1:0]    aluop2,
    output logic [2:0]        alu_ctrl,
    output logic [LEN-1:0]    ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);

    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [LEN-1:0]    rs1_data_q;
    logic [LEN-1:0]    rs2_data_q;
    logic [LEN-1:0]    imm_q;
    logic [LEN-1:0]    pc_q;
    logic              srca_pc_q;
    logic              srcb_imm_q;
    logic [LEN-1:0]    fwd_1;
    logic [LEN-1:0]    fwd_2;

    // Slot semantics: ex_valid marks a real instruction in EX; a slot with ex_valid=0 is a
    // bubble and its write/read controls are forced low so it has no architectural effect.
    // A PC-sourced operand 1 does not read rs1, so it cannot create a hazard on rs1.
    always_comb begin
        load_use_stall = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid &&
                         (((ex_rd_addr == id_rs1_addr) && !id_srca_pc) ||
                          (ex_rd_addr == id_rs2_addr));
    end

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && load_use_stall)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            alu_ctrl     <= 3'b000;
            ex_rd_addr   <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            srca_pc_q    <= 1'b0;
            srcb_imm_q   <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            alu_ctrl     <= id_alu_ctrl;
            ex_rd_addr   <= id_rd_addr;
            rs1_addr_q   <= id_rs1_addr;
            rs2_addr_q   <= id_rs2_addr;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            pc_q         <= id_pc;
            srca_pc_q    <= id_srca_pc;
            srcb_imm_q   <= id_srcb_imm;
        end
    end

    // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
    always_comb begin
        fwd_1 = rs1_data_q;
        if (mem_reg_write && (mem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0))
            fwd_1 = mem_result;
        else if (wb_reg_write && (wb_rd_addr == rs1_addr_q) && (rs1_addr_q != '0))
            fwd_1 = wb_result;

        fwd_2 = rs2_data_q;
        if (mem_reg_write && (mem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0))
            fwd_2 = mem_result;
        else if (wb_reg_write && (wb_rd_addr == rs2_addr_q) && (rs2_addr_q != '0))
            fwd_2 = wb_result;
    end

    always_comb begin
        aluop1        = srca_pc_q ? pc_q : fwd_1;
        aluop2        = srcb_imm_q ? imm_q : fwd_2;
        ex_store_data = fwd_2;
    end

endmodule
